ped_signal_ctrl: RTL and testbench

//   Pedestrian WALK / DON'T-WALK controller downstream of the vehicle light state machine.
//   - Consumes the vehicle lamp outputs (red/yellow/green) and a pedestrian push-button pulse.
//   - Grants a timed WALK phase, followed by a flashing clearance phase, only inside a vehicle red phase.
//   - Aborts to steady DON'T-WALK on any lamp conflict.

---
 rtl/ped_pkg.sv | 16 +
 rtl/ped_down_counter.sv | 28 ++
 rtl/ped_signal_ctrl.sv | 174 +++++++++++++++++
 tb/tb_ped_signal_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/ped_pkg.sv
// Shared definitions for the pedestrian signal controller:
// controller state encoding and the vehicle lamp legality check.
package ped_pkg;

    typedef enum logic [1:0] {
        PED_IDLE  = 2'b00,
        PED_WALK  = 2'b01,
        PED_FLASH = 2'b10
    } ped_state_t;

    // Vehicle lamps are legal only when exactly one of them is lit.
    function automatic logic lamp_legal(input logic red, input logic yellow, input logic green);
        return (red ^ yellow ^ green) & ~(red & yellow & green);
    endfunction

endpackage

// File: rtl/ped_down_counter.sv
// Loadable down counter that stops at zero; used for the phase timer
// and for the flash half-period timer of the pedestrian controller.
module ped_down_counter #(
    parameter int CNT_W = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] load_val,
    input  logic             load,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             zero
);

    // Load has priority; otherwise count down while enabled, holding at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/ped_signal_ctrl.sv
// Pedestrian WALK / DON'T-WALK controller sitting behind the vehicle light FSM.
// A latched button request is served at the next rising edge of vehicle red:
// steady WALK, then a flashing DON'T-WALK clearance, then steady DON'T-WALK.
// Loss of red or an illegal lamp combination aborts service with a fault pulse.
// Optional feature macro: PED_COUNTDOWN_EN (countdown output shows clocks left
// until the controller returns to IDLE; tied to 0 when undefined).
module ped_signal_ctrl
    import ped_pkg::*;
#(
    parameter int CNT_W        = 11,
    parameter int WALK_CYCLES  = 1500,
    parameter int FLASH_CYCLES = 500,
    parameter int BLINK_HALF   = 50
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             red,
    input  logic             yellow,
    input  logic             green,
    input  logic             ped_req,
    output logic             walk,
    output logic             dont_walk,
    output logic             req_pending,
    output logic             fault,
    output logic [CNT_W-1:0] countdown
);

    localparam logic [CNT_W-1:0] WALK_LOAD  = CNT_W'(WALK_CYCLES - 1);
    localparam logic [CNT_W-1:0] FLASH_LOAD = CNT_W'(FLASH_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLINK_LOAD = CNT_W'(BLINK_HALF - 1);

    ped_state_t       state;
    ped_state_t       next_state;
    logic             red_q;
    logic             red_rise;
    logic             legal;
    logic             blink_on;
    logic             next_blink_on;
    logic             pending_next;
    logic             fault_next;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_load_val;
    logic             cnt_en;
    logic [CNT_W-1:0] cnt_value;
    logic             cnt_zero;
    logic             blink_load;
    logic             blink_en;
    logic             blink_zero;

    assign red_rise = red & ~red_q;
    assign legal    = lamp_legal(red, yellow, green);

    ped_down_counter #(.CNT_W(CNT_W)) u_phase_cnt (
        .clk      (clk),
        .rst      (rst),
        .load_val (cnt_load_val),
        .load     (cnt_load),
        .en       (cnt_en),
        .count    (cnt_value),
        .zero     (cnt_zero)
    );

    // A one-clock half-period simply toggles every flash cycle, so no timer is needed.
    generate
        if (BLINK_HALF > 1) begin : g_blink_cnt
            logic [CNT_W-1:0] blink_value;
            logic             unused_blink_value;
            assign unused_blink_value = ^blink_value;
            ped_down_counter #(.CNT_W(CNT_W)) u_blink_cnt (
                .clk      (clk),
                .rst      (rst),
                .load_val (BLINK_LOAD),
                .load     (blink_load),
                .en       (blink_en),
                .count    (blink_value),
                .zero     (blink_zero)
            );
        end else begin : g_blink_none
            logic unused_blink;
            assign unused_blink = blink_load | blink_en | ^BLINK_LOAD;
            assign blink_zero   = 1'b1;
        end
    endgenerate

    // Next-state, timer control, request latch and fault decisions for one sampled cycle.
    always_comb begin
        next_state    = state;
        next_blink_on = blink_on;
        pending_next  = req_pending | ped_req;
        fault_next    = 1'b0;
        cnt_load      = 1'b0;
        cnt_load_val  = WALK_LOAD;
        cnt_en        = 1'b0;
        blink_load    = 1'b0;
        blink_en      = 1'b0;
        case (state)
            PED_IDLE: begin
                if (!legal) begin
                    fault_next = 1'b1;
                end else if (req_pending && red_rise) begin
                    next_state   = PED_WALK;
                    cnt_load     = 1'b1;
                    cnt_load_val = WALK_LOAD;
                    pending_next = 1'b0;
                end
            end
            PED_WALK: begin
                if (!red || !legal) begin
                    next_state = PED_IDLE;
                    fault_next = 1'b1;
                end else if (cnt_zero) begin
                    next_state    = PED_FLASH;
                    cnt_load      = 1'b1;
                    cnt_load_val  = FLASH_LOAD;
                    blink_load    = 1'b1;
                    next_blink_on = 1'b0;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            PED_FLASH: begin
                if (!red || !legal) begin
                    next_state = PED_IDLE;
                    fault_next = 1'b1;
                end else if (cnt_zero) begin
                    next_state = PED_IDLE;
                end else begin
                    cnt_en = 1'b1;
                    if (blink_zero) begin
                        next_blink_on = ~blink_on;
                        blink_load    = 1'b1;
                    end else begin
                        blink_en = 1'b1;
                    end
                end
            end
            default: begin
                next_state = PED_IDLE;
            end
        endcase
    end

    // State, edge detect, request latch and registered lamp/fault outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= PED_IDLE;
            red_q       <= 1'b0;
            blink_on    <= 1'b0;
            req_pending <= 1'b0;
            fault       <= 1'b0;
            walk        <= 1'b0;
            dont_walk   <= 1'b1;
        end else begin
            state       <= next_state;
            red_q       <= red;
            blink_on    <= next_blink_on;
            req_pending <= pending_next;
            fault       <= fault_next;
            walk        <= (next_state == PED_WALK);
            dont_walk   <= (next_state == PED_IDLE) ||
                           ((next_state == PED_FLASH) && next_blink_on);
        end
    end

`ifdef PED_COUNTDOWN_EN
    assign countdown = (state == PED_WALK)  ? cnt_value + CNT_W'(FLASH_CYCLES) :
                       (state == PED_FLASH) ? cnt_value : '0;
`else
    logic unused_cnt;
    assign unused_cnt = ^cnt_value;
    assign countdown  = '0;
`endif

endmodule

// File: tb/tb_ped_signal_ctrl.sv
// Directed self-checking bench for ped_signal_ctrl (WALK=8, FLASH=6, BLINK_HALF=2).
// A service-position model predicts every output each cycle; literal checks pin key points.
module tb_ped_signal_ctrl;

    localparam int CNT_W = 11;
    localparam int W     = 8;
    localparam int F     = 6;
    localparam int BH    = 2;
`ifdef PED_COUNTDOWN_EN
    localparam int CD_ON = 1;
`else
    localparam int CD_ON = 0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             red, yellow, green, ped_req;
    logic             walk, dont_walk, req_pending, fault;
    logic [CNT_W-1:0] countdown;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state: m_k is the index of the current service cycle (0..W+F-1), -1 when idle.
    int   m_k;
    logic m_pend, m_redq, m_fault;

    ped_signal_ctrl #(
        .CNT_W(CNT_W), .WALK_CYCLES(W), .FLASH_CYCLES(F), .BLINK_HALF(BH)
    ) dut (
        .clk(clk), .rst(rst), .red(red), .yellow(yellow), .green(green),
        .ped_req(ped_req), .walk(walk), .dont_walk(dont_walk),
        .req_pending(req_pending), .fault(fault), .countdown(countdown)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_checks++;
        if (actual == expected) n_pass++;
        else $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    endtask

    task automatic applyStimulus(input logic r, input logic y, input logic g, input logic req);
        red     = r;
        yellow  = y;
        green   = g;
        ped_req = req;
        @(negedge clk);
    endtask

    function automatic int expWalk();
        return (m_k >= 0 && m_k < W) ? 1 : 0;
    endfunction

    function automatic int expDontWalk();
        if (m_k < 0) return 1;
        if (m_k < W) return 0;
        return (((m_k - W) / BH) % 2 == 1) ? 1 : 0;
    endfunction

    function automatic int expCountdown();
        if (CD_ON == 0 || m_k < 0) return 0;
        return W + F - 1 - m_k;
    endfunction

    // Reference behaviour: advance the service position from the sampled lamps and button.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_k = -1; m_pend = 0; m_redq = 0; m_fault = 0;
        end else begin
            automatic logic lg = ($countones({red, yellow, green}) == 1);
            m_fault = !lg || (m_k >= 0 && !red);
            if (m_k >= 0) begin
                if (!lg || !red) m_k = -1;
                else if (m_k == W + F - 1) m_k = -1;
                else m_k++;
                if (ped_req) m_pend = 1;
            end else if (m_pend && red && !m_redq && lg) begin
                m_k = 0;
                m_pend = 0;
            end else if (ped_req) begin
                m_pend = 1;
            end
            m_redq = red;
        end
    end

    // Every cycle out of reset, compare all outputs with the model.
    always @(negedge clk) begin
        if (!rst) begin
            checkOutput("model_walk", walk, expWalk());
            checkOutput("model_dont_walk", dont_walk, expDontWalk());
            checkOutput("model_req_pending", req_pending, m_pend);
            checkOutput("model_fault", fault, m_fault);
            checkOutput("model_countdown", countdown, expCountdown());
            checkOutput("lamps_exclusive", walk & dont_walk, 0);
        end
    end

    logic       walk_seq [16];
    logic       dw_seq   [16];
    int         cd_seq   [16];
    int         walk_len;
    int         fault_seen;
    logic [5:0] flash_pat;

    initial begin
        rst = 1'b1; red = 0; yellow = 0; green = 1; ped_req = 0;
        repeat (2) @(negedge clk);
        checkOutput("reset_walk", walk, 0);
        checkOutput("reset_dont_walk", dont_walk, 1);
        checkOutput("reset_pending", req_pending, 0);
        checkOutput("reset_fault", fault, 0);
        checkOutput("reset_countdown", countdown, 0);
        rst = 1'b0;

        // Request on green, then yellow, then red rises and WALK is granted.
        applyStimulus(0, 0, 1, 1);
        checkOutput("s2_pending_set", req_pending, 1);
        applyStimulus(0, 1, 0, 0);
        checkOutput("s2_pending_hold", req_pending, 1);
        applyStimulus(1, 0, 0, 0);
        checkOutput("s2_grant_pending_clr", req_pending, 0);
        fault_seen = 0;
        for (int k = 0; k < 16; k++) begin
            walk_seq[k] = walk;
            dw_seq[k]   = dont_walk;
            cd_seq[k]   = int'(countdown);
            if (fault) fault_seen++;
            applyStimulus(1, 0, 0, 0);
        end
        walk_len = 0;
        for (int k = 0; k < 16; k++) walk_len += int'(walk_seq[k]);
        checkOutput("s2_walk_len", walk_len, 8);
        checkOutput("s2_walk_last", walk_seq[7], 1);
        flash_pat = {dw_seq[8], dw_seq[9], dw_seq[10], dw_seq[11], dw_seq[12], dw_seq[13]};
        checkOutput("s2_flash_pattern", flash_pat, 6'b001100);
        checkOutput("s2_steady_dont_walk", dw_seq[14], 1);
        checkOutput("s2_no_fault", fault_seen, 0);
        checkOutput("s6_cd_first_walk", cd_seq[0], CD_ON ? 13 : 0);
        checkOutput("s6_cd_last_walk", cd_seq[7], CD_ON ? 6 : 0);
        checkOutput("s6_cd_first_flash", cd_seq[8], CD_ON ? 5 : 0);
        checkOutput("s6_cd_last_flash", cd_seq[13], CD_ON ? 0 : 0);

        // Red rise without request; then request while red already high.
        applyStimulus(0, 0, 1, 0);
        applyStimulus(1, 0, 0, 0);
        checkOutput("s3_no_req_no_walk", walk, 0);
        applyStimulus(1, 0, 0, 1);
        checkOutput("s3_req_in_red", req_pending, 1);
        applyStimulus(1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0);
        checkOutput("s3_no_grant_without_rise", walk, 0);
        applyStimulus(0, 0, 1, 0);
        applyStimulus(1, 0, 0, 0);
        checkOutput("s3_grant_next_red", walk, 1);

        // Red drops during the third WALK cycle: abort with one fault pulse.
        applyStimulus(1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 0, 1, 0);
        checkOutput("s4_abort_walk", walk, 0);
        checkOutput("s4_abort_dont_walk", dont_walk, 1);
        checkOutput("s4_abort_fault", fault, 1);
        checkOutput("s4_abort_countdown", countdown, 0);
        applyStimulus(0, 0, 1, 0);
        checkOutput("s4_fault_one_cycle", fault, 0);

        // Illegal lamps in IDLE, then a request coinciding with the grant edge.
        applyStimulus(1, 1, 0, 0);
        checkOutput("s5_illegal_fault1", fault, 1);
        applyStimulus(1, 1, 0, 0);
        checkOutput("s5_illegal_fault2", fault, 1);
        checkOutput("s5_illegal_walk", walk, 0);
        applyStimulus(0, 0, 1, 0);
        checkOutput("s5_fault_clear", fault, 0);
        applyStimulus(0, 0, 1, 1);
        applyStimulus(1, 0, 0, 1);
        checkOutput("s5_grant_walk", walk, 1);
        checkOutput("s5_grant_clears_pending", req_pending, 0);

        // Request during service waits for the next red phase.
        applyStimulus(1, 0, 0, 1);
        checkOutput("s5_req_in_walk", req_pending, 1);
        repeat (13) applyStimulus(1, 0, 0, 0);
        checkOutput("s5_idle_after_service", dont_walk, 1);
        checkOutput("s5_still_pending", req_pending, 1);
        applyStimulus(1, 0, 0, 0);
        checkOutput("s5_no_regrant_same_red", walk, 0);
        applyStimulus(0, 0, 1, 0);
        applyStimulus(1, 0, 0, 0);
        checkOutput("s5_regrant_next_red", walk, 1);
        applyStimulus(1, 0, 0, 0);

        // Reset mid-run takes effect immediately.
        #2 rst = 1'b1;
        #1;
        checkOutput("s1_rst_walk", walk, 0);
        checkOutput("s1_rst_dont_walk", dont_walk, 1);
        checkOutput("s1_rst_pending", req_pending, 0);
        checkOutput("s1_rst_fault", fault, 0);
        checkOutput("s1_rst_countdown", countdown, 0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(0, 0, 1, 0);
        checkOutput("s1_after_rst_walk", walk, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
